// File: rtl/key_uart_pkg.sv
// Shared types and constants for the keyboard UART transmit path.
// Holds the serializer state encoding and the frame lengths in bit periods.
// Also provides a helper that picks the frame length for a given parity setting.
package key_uart_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } state_t;

  localparam int FRAME_BITS_8N1 = 10;
  localparam int FRAME_BITS_8E1 = 11;

  function automatic int frame_bits(input bit parity);
    return parity ? FRAME_BITS_8E1 : FRAME_BITS_8N1;
  endfunction

endpackage

// File: rtl/key_fifo.sv
// Purpose: parameterized synchronous FIFO with occupancy count, full and empty flags.
// Latency: a pushed word is visible on pop_data the edge after the push; pop_data shows the head combinationally.
// Backpressure: push is ignored while full and pop is ignored while empty; callers gate with full/empty.
// Ports: clk, resetn (async active-low), push/push_data, pop/pop_data, count (0..DEPTH), full, empty.
module key_fifo #(
  parameter int DEPTH = 8,
  parameter int W     = 8,
  localparam int AW   = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          resetn,
  input  logic          push,
  input  logic [W-1:0]  push_data,
  input  logic          pop,
  output logic [W-1:0]  pop_data,
  output logic [AW:0]   count,
  output logic          full,
  output logic          empty
);

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic          do_push;
  logic          do_pop;

  assign full     = (count == (AW+1)'(DEPTH));
  assign empty    = (count == '0);
  assign do_push  = push && !full;
  assign do_pop   = pop && !empty;
  assign pop_data = mem[rd_ptr];

  // Storage carries no reset; validity is tracked entirely by count.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

  // DEPTH is a power of two, so the pointers wrap naturally.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + (AW+1)'(1);
        2'b01:   count <= count - (AW+1)'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/key_uart_tx.sv
// Purpose: buffers ASCII strobes in a small FIFO and serializes them LSB first on tx (8N1, or 8E1 with KEY_UART_PARITY_EN).
// Latency: byte accepted at edge k into an idle, empty path drives the start bit from edge k+1; a frame lasts FRAME_BITS*DIV cycles.
// Backpressure: in_ready drops when the FIFO is full; strobes refused while full are counted in drop_cnt (saturating at 255).
// Ports: clk, resetn (async active-low), in_data/in_valid/in_ready, tx (registered, idle high), busy, fifo_cnt, drop_cnt.
// Build option: define KEY_UART_PARITY_EN to add an even-parity bit between the data bits and the stop bit.
module key_uart_tx
  import key_uart_pkg::*;
#(
  parameter int CLK_HZ     = 50000000,
  parameter int BAUD       = 115200,
  parameter int FIFO_DEPTH = 8,
  localparam int AW        = $clog2(FIFO_DEPTH)
) (
  input  logic          clk,
  input  logic          resetn,
  input  logic [7:0]    in_data,
  input  logic          in_valid,
  output logic          in_ready,
  output logic          tx,
  output logic          busy,
  output logic [AW:0]   fifo_cnt,
  output logic [7:0]    drop_cnt
);

  localparam int DIV = CLK_HZ / BAUD;
  localparam int BW  = $clog2(DIV);
  localparam logic [BW-1:0] BAUD_LAST = BW'(DIV - 1);

`ifdef KEY_UART_PARITY_EN
  localparam bit     PARITY_ON  = 1'b1;
  localparam state_t AFTER_DATA = PARITY;
`else
  localparam bit     PARITY_ON  = 1'b0;
  localparam state_t AFTER_DATA = STOP;
`endif
  localparam int FRAME_BITS = frame_bits(PARITY_ON);
  localparam int DATA_BITS  = FRAME_BITS - 2 - int'(PARITY_ON);

  state_t          state_q, state_d;
  logic [BW-1:0]   baud_q, baud_d;
  logic [2:0]      bit_q, bit_d;
  logic [7:0]      shift_q, shift_d;
  logic            tx_q, tx_d;
  logic [7:0]      drop_q;
  logic            bit_end;

  logic            fifo_pop;
  logic [7:0]      fifo_head;
  logic            fifo_full;
  logic            fifo_empty;

`ifdef KEY_UART_PARITY_EN
  logic            par_q, par_d;
`endif

  key_fifo #(
    .DEPTH (FIFO_DEPTH),
    .W     (8)
  ) u_fifo (
    .clk       (clk),
    .resetn    (resetn),
    .push      (in_valid && in_ready),
    .push_data (in_data),
    .pop       (fifo_pop),
    .pop_data  (fifo_head),
    .count     (fifo_cnt),
    .full      (fifo_full),
    .empty     (fifo_empty)
  );

  assign in_ready = !fifo_full;
  assign busy     = (state_q != IDLE) || !fifo_empty;
  assign tx       = tx_q;
  assign drop_cnt = drop_q;
  assign bit_end  = (baud_q == BAUD_LAST);

  // State register; tx is registered together with the state so the line
  // changes on the same edge the FSM moves.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q <= IDLE;
      baud_q  <= '0;
      bit_q   <= '0;
      shift_q <= '0;
      tx_q    <= 1'b1;
    end else begin
      state_q <= state_d;
      baud_q  <= baud_d;
      bit_q   <= bit_d;
      shift_q <= shift_d;
      tx_q    <= tx_d;
    end
  end

`ifdef KEY_UART_PARITY_EN
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) par_q <= 1'b0;
    else         par_q <= par_d;
  end
`endif

  // Next-state logic. The baud counter restarts on every state entry.
  always_comb begin
    state_d = state_q;
    baud_d  = baud_q + BW'(1);
    bit_d   = bit_q;
    shift_d = shift_q;
`ifdef KEY_UART_PARITY_EN
    par_d   = par_q;
`endif
    case (state_q)
      IDLE: begin
        baud_d = '0;
        if (!fifo_empty) begin
          state_d = START;
          shift_d = fifo_head;
`ifdef KEY_UART_PARITY_EN
          par_d   = ^fifo_head;
`endif
        end
      end
      START: begin
        if (bit_end) begin
          state_d = DATA;
          baud_d  = '0;
          bit_d   = '0;
        end
      end
      DATA: begin
        if (bit_end) begin
          baud_d  = '0;
          shift_d = {1'b0, shift_q[7:1]};
          if (bit_q == 3'(DATA_BITS - 1)) state_d = AFTER_DATA;
          else                            bit_d   = bit_q + 3'd1;
        end
      end
`ifdef KEY_UART_PARITY_EN
      PARITY: begin
        if (bit_end) begin
          state_d = STOP;
          baud_d  = '0;
        end
      end
`endif
      STOP: begin
        if (bit_end) begin
          state_d = IDLE;
          baud_d  = '0;
        end
      end
      default: begin
        state_d = IDLE;
        baud_d  = '0;
      end
    endcase
  end

  // Outputs: the pop coincides with leaving IDLE; tx is the line level for
  // the state being entered.
  always_comb begin
    fifo_pop = (state_q == IDLE) && !fifo_empty;
    tx_d     = 1'b1;
    case (state_d)
      START:  tx_d = 1'b0;
      DATA:   tx_d = shift_d[0];
`ifdef KEY_UART_PARITY_EN
      PARITY: tx_d = par_d;
`endif
      default: tx_d = 1'b1;
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      drop_q <= '0;
    end else if (in_valid && !in_ready && (drop_q != 8'hFF)) begin
      drop_q <= drop_q + 8'd1;
    end
  end

endmodule

// File: tb/tb_key_uart_tx.sv
// Directed bench for key_uart_tx with DIV=16 and an 8-entry FIFO.
// A negedge monitor decodes frames off tx; the main thread drives strobes and checks.
module tb_key_uart_tx;
  import key_uart_pkg::*;

  localparam int DIVT = 16;
`ifdef KEY_UART_PARITY_EN
  localparam int FB = FRAME_BITS_8E1;
`else
  localparam int FB = FRAME_BITS_8N1;
`endif
  localparam int FRAME_CYC = DIVT * FB;

  logic       clk = 1'b0;
  logic       resetn;
  logic [7:0] in_data;
  logic       in_valid;
  logic       in_ready;
  logic       tx;
  logic       busy;
  logic [3:0] fifo_cnt;
  logic [7:0] drop_cnt;

  int n_cmp = 0;
  int n_bad = 0;
  int cyc   = 0;
  int epoch = 0;
  logic [3:0] peak;

  logic [7:0] rx_dat[$];
  int         rx_start[$];
  logic       rx_stop[$];
  logic       rx_par[$];

  key_uart_tx #(
    .CLK_HZ     (16),
    .BAUD       (1),
    .FIFO_DEPTH (8)
  ) dut (
    .clk      (clk),
    .resetn   (resetn),
    .in_data  (in_data),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .tx       (tx),
    .busy     (busy),
    .fifo_cnt (fifo_cnt),
    .drop_cnt (drop_cnt)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Frame decoder: samples mid-bit; frames cut by a reset are discarded.
  initial begin : mon
    logic [7:0] d;
    logic       p;
    logic       sb;
    int         s;
    int         ep;
    forever begin
      @(negedge clk);
      if (resetn === 1'b1 && tx === 1'b0) begin
        s  = cyc;
        ep = epoch;
        p  = 1'b0;
        repeat (8) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
          repeat (DIVT) @(negedge clk);
          d[i] = tx;
        end
`ifdef KEY_UART_PARITY_EN
        repeat (DIVT) @(negedge clk);
        p = tx;
`endif
        repeat (DIVT) @(negedge clk);
        sb = tx;
        if (ep == epoch) begin
          rx_dat.push_back(d);
          rx_start.push_back(s);
          rx_stop.push_back(sb);
          rx_par.push_back(p);
        end
      end
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
    n_cmp++;
    if (got !== want) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h want 0x%0h", tag, got, want);
    end
  endtask

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
      if (fifo_cnt > peak) peak = fifo_cnt;
    end
  endtask

  task automatic apply_reset();
    #2 resetn = 1'b0;
    epoch++;
    in_valid = 1'b0;
    repeat (2) @(posedge clk);
    #1 resetn = 1'b1;
  endtask

  task automatic wait_frames(input string tag, input int n, input int budget);
    int t = 0;
    while (rx_dat.size() < n && t < budget) begin
      step(1);
      t++;
    end
    check(tag, rx_dat.size(), n);
  endtask

  task automatic wait_idle(input string tag, input int budget);
    int t = 0;
    while (busy !== 1'b0 && t < budget) begin
      step(1);
      t++;
    end
    check(tag, busy, 1'b0);
  endtask

  bit   exp_a [8] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
  int   b;
  int   k;
  int   lows;

  initial begin
    resetn   = 1'b0;
    in_valid = 1'b0;
    in_data  = 8'h00;
    peak     = '0;

    // Reset state
    step(2);
    check("rst_tx", tx, 1'b1);
    check("rst_busy", busy, 1'b0);
    check("rst_in_ready", in_ready, 1'b1);
    check("rst_fifo_cnt", fifo_cnt, 4'd0);
    check("rst_drop_cnt", drop_cnt, 8'd0);
    resetn = 1'b1;
    step(2);

    // 1: single byte 0x41, bit-by-bit timing
    in_data = 8'h41; in_valid = 1'b1;
    step(1);
    in_valid = 1'b0;
    check("t1_busy_on_accept", busy, 1'b1);
    check("t1_cnt_on_accept", fifo_cnt, 4'd1);
    check("t1_tx_still_idle", tx, 1'b1);
    step(1);
    check("t1_start_edge", tx, 1'b0);
    check("t1_cnt_popped", fifo_cnt, 4'd0);
    step(8);
    check("t1_start_mid", tx, 1'b0);
    for (int i = 0; i < 8; i++) begin
      step(DIVT);
      check($sformatf("t1_bit%0d", i), tx, exp_a[i]);
    end
`ifdef KEY_UART_PARITY_EN
    step(DIVT);
    check("t1_parity", tx, 1'b0);
`endif
    step(DIVT);
    check("t1_stop", tx, 1'b1);
    step(7);
    check("t1_busy_last", busy, 1'b1);
    step(1);
    check("t1_busy_off", busy, 1'b0);
    check("t1_rx_byte", rx_dat[0], 8'h41);

    // 2: back-to-back 0x48, 0x49
    b = rx_dat.size();
    peak = '0;
    in_data = 8'h48; in_valid = 1'b1;
    step(1);
    in_data = 8'h49;
    step(1);
    in_valid = 1'b0;
    wait_frames("t2_frames", b + 2, 2 * FRAME_CYC + 50);
    if (rx_dat.size() >= b + 2) begin
      check("t2_byte0", rx_dat[b], 8'h48);
      check("t2_byte1", rx_dat[b+1], 8'h49);
      check("t2_stop0", rx_stop[b], 1'b1);
      check("t2_spacing", rx_start[b+1] - rx_start[b], FRAME_CYC + 1);
      check("t2_gap_high", rx_start[b+1] - rx_start[b] - (FRAME_CYC - DIVT), 17);
    end
    check("t2_peak_cnt", peak, 4'd1);
    wait_idle("t2_idle", 200);

    // 3: overflow, 12-cycle hold from idle
    apply_reset();
    b = rx_dat.size();
    for (int i = 0; i < 12; i++) begin
      in_data = 8'h60 + 8'(i); in_valid = 1'b1;
      step(1);
    end
    in_valid = 1'b0;
    check("t3_in_ready", in_ready, 1'b0);
    check("t3_fifo_full", fifo_cnt, 4'd8);
    check("t3_drop", drop_cnt, 8'd3);
    wait_frames("t3_frames", b + 9, 9 * (FRAME_CYC + 1) + 50);
    if (rx_dat.size() >= b + 9) begin
      for (int i = 0; i < 9; i++) begin
        check($sformatf("t3_byte%0d", i), rx_dat[b+i], 8'h60 + 8'(i));
        check($sformatf("t3_stop%0d", i), rx_stop[b+i], 1'b1);
      end
    end
    wait_idle("t3_idle", 200);

    // 4: drop counter saturation
    apply_reset();
    in_data = 8'h70; in_valid = 1'b1;
    step(300);
    in_valid = 1'b0;
    check("t4_drop_sat", drop_cnt, 8'd255);
    check("t4_full", fifo_cnt, 4'd8);
    check("t4_in_ready", in_ready, 1'b0);

    // 5: asynchronous reset during data bit 3
    apply_reset();
    in_data = 8'h55; in_valid = 1'b1;
    step(1);
    in_data = 8'h33;
    step(1);
    in_valid = 1'b0;
    step(69);
    check("t5_bit3_low", tx, 1'b0);
    check("t5_cnt_before", fifo_cnt, 4'd1);
    check("t5_busy_before", busy, 1'b1);
    #2 resetn = 1'b0;
    epoch++;
    #1;
    check("t5_tx_async", tx, 1'b1);
    check("t5_cnt_async", fifo_cnt, 4'd0);
    check("t5_busy_async", busy, 1'b0);
    check("t5_ready_async", in_ready, 1'b1);
    @(posedge clk);
    #1 resetn = 1'b1;
    b = rx_dat.size();
    lows = 0;
    for (int i = 0; i < 200; i++) begin
      step(1);
      if (tx !== 1'b1) lows++;
    end
    check("t5_no_low_after", lows, 0);
    check("t5_no_frame", rx_dat.size(), b);
    check("t5_busy_after", busy, 1'b0);

`ifdef KEY_UART_PARITY_EN
    // 6: even parity
    b = rx_dat.size();
    in_data = 8'h07; in_valid = 1'b1;
    step(1);
    in_valid = 1'b0;
    k = cyc;
    wait_idle("t6_idle", 300);
    check("t6_frame_len", cyc - k, 177);
    in_data = 8'h03; in_valid = 1'b1;
    step(1);
    in_valid = 1'b0;
    wait_frames("t6_frames", b + 2, 400);
    if (rx_dat.size() >= b + 2) begin
      check("t6_byte07", rx_dat[b], 8'h07);
      check("t6_par07", rx_par[b], 1'b1);
      check("t6_byte03", rx_dat[b+1], 8'h03);
      check("t6_par03", rx_par[b+1], 1'b0);
    end
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/key_uart_tx.md
Name: key_uart_tx

Overview:
- Downstream consumer of the keyboard path: accepts ASCII bytes (one-cycle strobes from the scancode-to-ASCII stage) and transmits them on the board UART TX line.
- Format is 8N1, LSB first.
- A small FIFO absorbs typing bursts while a byte is being serialized.
- Sits between the keyboard/ASCII logic and the top-level `uart_tx` pin.

Parameters:
- CLK_HZ, 50000000, system clock frequency in Hz.
- BAUD, 115200, line rate. localparam DIV = CLK_HZ/BAUD (integer truncation) gives clocks per bit; DIV must be ≥ 2.
- FIFO_DEPTH, 8, entries. Must be a power of two, ≥ 2. localparam AW = $clog2(FIFO_DEPTH).

Ports:
- clk  in  1  system clock, rising edge.
- resetn  in  1  asynchronous active-low reset.
- in_data  in  8  ASCII byte to send.
- in_valid  in  1  in_data is valid this cycle (single-cycle strobe or held).
- in_ready  out  1  FIFO not full; a byte is accepted on an edge where in_valid && in_ready.
- tx  out  1  serial line, idle high, registered.
- busy  out  1  serializer not in IDLE, or FIFO not empty.
- fifo_cnt  out  AW+1  current FIFO occupancy, 0..FIFO_DEPTH.
- drop_cnt  out  8  count of strobes rejected because the FIFO was full; saturates at 255.

Behaviour:
- Reset (resetn low, asynchronous, any time, including mid-frame):
  - tx=1, busy=0, in_ready=1, fifo_cnt=0, drop_cnt=0.
  - FIFO pointers cleared; FSM to IDLE; bit counter and baud counter cleared.
  - A frame in progress is aborted; no glitch low after release.
- FIFO:
  - Circular buffer with wr_ptr and rd_ptr of AW bits, plus a count register.
  - Push when in_valid && in_ready. Pop when the FSM leaves IDLE.
  - Push and pop on the same edge: both happen, count unchanged.
  - in_ready = (fifo_cnt != FIFO_DEPTH), combinational from the count. When full, a push is refused even if a pop occurs that edge.
  - in_valid && !in_ready: drop_cnt += 1, saturating at 255.
- FSM states: IDLE, START, DATA, STOP.
  - IDLE: tx=1. If FIFO non-empty, load the head byte into the shift register, pop, go to START.
  - START: tx=0 for DIV cycles, then DATA with bit index 0.
  - DATA: tx=shift[0] for DIV cycles per bit, shift right after each bit. After bit 7, go to STOP.
  - STOP: tx=1 for DIV cycles, then IDLE.
  - Back-to-back bytes: one IDLE cycle between the end of STOP and the next START, i.e. an inter-frame gap of DIV+1 cycles of tx high.
- Baud counter:
  - Counts 0..DIV-1 within each bit; it is the only timing source.
  - Reset to 0 on every state entry.
- Latency:
  - Byte accepted at edge k into an empty FIFO with the FSM in IDLE → FSM enters START at edge k+1 → tx is low from edge k+1 (tx registered alongside the state).
  - A full frame occupies exactly 10*DIV cycles, from edge k+1 to the return to IDLE.
- busy rises on the accepting edge and falls on the edge the FSM returns to IDLE with the FIFO empty.

Optional Feature:
- Macro: KEY_UART_PARITY_EN.
- Defined:
  - A PARITY state is inserted between DATA and STOP, lasting DIV cycles.
  - tx = even parity (XOR of the 8 data bits, computed at load).
  - Frame is 11*DIV cycles (8E1).
- Undefined: 8N1 as above, and no parity logic is synthesized.

Decomposition:
- Shared package key_uart_pkg holds:
  - state enum (IDLE, START, DATA, PARITY, STOP);
  - frame-length constants (FRAME_BITS_8N1 = 10, FRAME_BITS_8E1 = 11).
- Natural sub-module: key_fifo, a parameterized synchronous FIFO with count, full and empty flags and the same clk/resetn, reusable elsewhere in the keyboard path.
- The serializer FSM stays in key_uart_tx.

Test Plan:
1. Setup CLK_HZ=16, BAUD=1 (DIV=16); single strobe in_data=0x41 → tx low from the next edge. Then 16-cycle bits 1,0,0,0,0,0,1,0, then high; busy=0 exactly 160 cycles after the start edge.
2. Back-to-back: strobe 0x48 then 0x49 on consecutive cycles → two frames separated by exactly 17 cycles of tx=1; fifo_cnt peaks at 1.
3. Overflow, FIFO_DEPTH=8: hold in_valid for 12 cycles while idle → 9 bytes accepted (1 popped immediately + 8 stored). in_ready low thereafter; drop_cnt=3. All 9 bytes emerge in order.
4. drop_cnt saturation: FIFO full, hold in_valid 300 cycles → drop_cnt=255, no wrap.
5. Reset mid-frame: assert resetn=0 during data bit 3 → tx=1, fifo_cnt=0, busy=0 immediately (asynchronous). After release, no frame is emitted until a new strobe arrives.
6. With KEY_UART_PARITY_EN defined: send 0x07 (three ones) → parity bit 1, frame of 176 cycles. Send 0x03 → parity bit 0.
